nonce_scheduler: RTL and testbench

- Sequences a single `miner_core` through a contiguous nonce range for one 608-bit header and a 256-bit target.
- Launches one hash per nonce and waits for `finished`.
- Stops on the first `correct` result, on range exhaustion, on abort, or on a per-hash timeout.
- Sits between the host/config interface and `miner_core`, and owns all of that core's inputs.

---
 rtl/miner_pkg.sv | 22 ++
 rtl/nonce_counter.sv | 53 +++++
 rtl/nonce_scheduler.sv | 173 +++++++++++++++++
 tb/tb_nonce_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared widths, scheduler state encoding and nonce byte-order helper.
package miner_pkg;

  localparam int unsigned BLOCK_W = 608;
  localparam int unsigned HASH_W  = 256;
  localparam int unsigned NONCE_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StFound,
    StExhausted,
    StError
  } sched_state_t;

  // Reverse the byte order of a 32-bit word.
  function automatic logic [NONCE_W-1:0] byteswap32(input logic [NONCE_W-1:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/nonce_counter.sv
// Search counter with load/increment-with-wrap and last-value compare, plus the
// completed-hash counter (one bit wider so a full 2^32 sweep does not overflow).
module nonce_counter
  import miner_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load_i,
  input  logic [NONCE_W-1:0] first_i,
  input  logic               inc_i,
  input  logic [NONCE_W-1:0] last_i,
  input  logic               att_clr_i,
  input  logic               att_inc_i,
  output logic [NONCE_W-1:0] cur_o,
  output logic               is_last_o,
  output logic [NONCE_W:0]   attempts_o
);

  logic [NONCE_W-1:0] cur_d, cur_q;
  logic [NONCE_W:0]   att_d, att_q;

  // Next counter values; load and clear win over increment.
  always_comb begin
    cur_d = cur_q;
    att_d = att_q;
    if (load_i) begin
      cur_d = first_i;
    end else if (inc_i) begin
      cur_d = cur_q + NONCE_W'(1);
    end
    if (att_clr_i) begin
      att_d = '0;
    end else if (att_inc_i) begin
      att_d = att_q + (NONCE_W + 1)'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cur_q <= '0;
      att_q <= '0;
    end else begin
      cur_q <= cur_d;
      att_q <= att_d;
    end
  end

  assign cur_o      = cur_q;
  assign is_last_o  = (cur_q == last_i);
  assign attempts_o = att_q;

endmodule

// File: rtl/nonce_scheduler.sv
// Walks one miner_core through a contiguous nonce range, one hash at a time,
// stopping on a hit, range exhaustion, abort or a per-hash timeout.
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int unsigned TIMEOUT        = 1023,
  parameter bit          NONCE_BYTESWAP = 1'b1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [BLOCK_W-1:0] block_in,
  input  logic [HASH_W-1:0]  target_in,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  output logic               hash_enable,
  output logic [BLOCK_W-1:0] block,
  output logic [NONCE_W-1:0] nonce,
  output logic [HASH_W-1:0]  target,
  input  logic               finished,
  input  logic               correct,
  input  logic [HASH_W-1:0]  hashed,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic               timeout_err,
  output logic               done,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [HASH_W-1:0]  found_hash,
  output logic [NONCE_W:0]   attempts
);

  // Timer counts WAIT cycles 0..TIMEOUT-1; the edge after TmrLast enters ERROR.
  localparam int unsigned TmrW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  sched_state_t       state_d, state_q;
  logic [TmrW-1:0]    tmr_d, tmr_q;
  logic [BLOCK_W-1:0] block_d, block_q;
  logic [HASH_W-1:0]  target_d, target_q;
  logic [NONCE_W-1:0] last_d, last_q;
  logic [NONCE_W-1:0] fnonce_d, fnonce_q;
  logic [HASH_W-1:0]  fhash_d, fhash_q;
  logic               done_d, done_q;

  logic               idle_like, accept, wait_fin, hit, advance;
  logic [NONCE_W-1:0] cur;
  logic               is_last;

  nonce_counter u_counter (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (accept),
    .first_i    (nonce_first),
    .inc_i      (advance),
    .last_i     (last_q),
    .att_clr_i  (accept),
    .att_inc_i  (wait_fin),
    .cur_o      (cur),
    .is_last_o  (is_last),
    .attempts_o (attempts)
  );

  // Handshake decode shared by the FSM and datapath; abort masks everything.
  always_comb begin
    idle_like = (state_q == StIdle) || (state_q == StFound) ||
                (state_q == StExhausted) || (state_q == StError);
    accept    = start && !abort && idle_like;
    wait_fin  = !abort && (state_q == StWait) && finished;
    hit       = wait_fin && correct;
    advance   = wait_fin && !correct && !is_last;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StFound, StExhausted, StError: begin
          if (start) state_d = StLaunch;
        end
        StLaunch: state_d = StWait;
        StWait: begin
          if (finished) begin
            if (correct)      state_d = StFound;
            else if (is_last) state_d = StExhausted;
            else              state_d = StLaunch;
          end else if (tmr_q == TmrLast) begin
            state_d = StError;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs; sticky flags are the terminal states themselves.
  always_comb begin
    hash_enable = (state_q == StLaunch) && !abort;
    busy        = (state_q == StLaunch) || (state_q == StWait);
    found       = (state_q == StFound);
    exhausted   = (state_q == StExhausted);
    timeout_err = (state_q == StError);
  end

  // Datapath next state: latches, capture registers, timer and done pulse.
  always_comb begin
    block_d  = block_q;
    target_d = target_q;
    last_d   = last_q;
    fnonce_d = fnonce_q;
    fhash_d  = fhash_q;
    tmr_d    = tmr_q;
    if (accept) begin
      block_d  = block_in;
      target_d = target_in;
      last_d   = nonce_last;
      fnonce_d = '0;
      fhash_d  = '0;
    end else if (hit) begin
      fnonce_d = cur;
      fhash_d  = hashed;
    end
    if (state_q == StLaunch) begin
      tmr_d = '0;
    end else if (state_q == StWait && !finished) begin
      tmr_d = tmr_q + TmrW'(1);
    end
    done_d = (state_q == StWait) &&
             ((state_d == StFound) || (state_d == StExhausted) || (state_d == StError));
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      block_q  <= '0;
      target_q <= '0;
      last_q   <= '0;
      fnonce_q <= '0;
      fhash_q  <= '0;
      tmr_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      block_q  <= block_d;
      target_q <= target_d;
      last_q   <= last_d;
      fnonce_q <= fnonce_d;
      fhash_q  <= fhash_d;
      tmr_q    <= tmr_d;
      done_q   <= done_d;
    end
  end

  assign block       = block_q;
  assign target      = target_q;
  assign nonce       = NONCE_BYTESWAP ? byteswap32(cur) : cur;
  assign found_nonce = fnonce_q;
  assign found_hash  = fhash_q;
  assign done        = done_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Scoreboarded bench: expected launch counters are queued when a search starts
// and popped on every hash_enable; a small core model answers each launch.
module tb_nonce_scheduler;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start, abort;
  logic [607:0] block_in;
  logic [255:0] target_in;
  logic [31:0]  nonce_first, nonce_last;
  logic         hash_enable;
  logic [607:0] block;
  logic [31:0]  nonce;
  logic [255:0] target;
  logic         finished, correct;
  logic [255:0] hashed;
  logic         busy, found, exhausted, timeout_err, done;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [32:0]  attempts;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  int          he_count = 0;

  // Core model controls.
  logic        mute, hit_en;
  logic [31:0] hit_val;
  logic        pend;
  logic [1:0]  lat_cnt;
  logic [31:0] lnonce;

  nonce_scheduler #(
    .TIMEOUT        (8),
    .NONCE_BYTESWAP (1'b1)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .abort       (abort),
    .block_in    (block_in),
    .target_in   (target_in),
    .nonce_first (nonce_first),
    .nonce_last  (nonce_last),
    .hash_enable (hash_enable),
    .block       (block),
    .nonce       (nonce),
    .target      (target),
    .finished    (finished),
    .correct     (correct),
    .hashed      (hashed),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .timeout_err (timeout_err),
    .done        (done),
    .found_nonce (found_nonce),
    .found_hash  (found_hash),
    .attempts    (attempts)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tb_swap(input logic [31:0] v);
    logic [31:0] r;
    r = {<<8{v}};
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [607:0] got, input logic [607:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core model: finishes two cycles after seeing a launch; hit on one counter.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      finished <= 1'b0;
      correct  <= 1'b0;
      hashed   <= '0;
      pend     <= 1'b0;
      lat_cnt  <= '0;
      lnonce   <= '0;
    end else if (hash_enable) begin
      finished <= 1'b0;
      correct  <= 1'b0;
      pend     <= !mute;
      lat_cnt  <= 2'd1;
      lnonce   <= nonce;
    end else if (pend) begin
      if (lat_cnt == 2'd0) begin
        finished <= 1'b1;
        pend     <= 1'b0;
        correct  <= hit_en && (tb_swap(lnonce) == hit_val);
        hashed   <= {8{lnonce}};
      end else begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end
  end

  // Scoreboard: every launch must present the next expected counter, swapped.
  always @(negedge clk) begin
    if (n_rst && hash_enable) begin
      he_count++;
      if (exp_q.size() == 0) begin
        check_eq("launch_unexpected", 608'(nonce), 608'(32'hFFFF_FFFF) ^ 608'(nonce) ^ 608'(1));
      end else begin
        check_eq("launch_nonce", 608'(nonce), 608'(tb_swap(exp_q.pop_front())));
      end
    end
  end

  task automatic push_exp(input logic [31:0] first, input logic [31:0] last,
                          input bit hen, input logic [31:0] hv);
    logic [31:0] c;
    c = first;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(c);
      if ((hen && c == hv) || c == last) break;
      c = c + 32'd1;
    end
  endtask

  task automatic do_start(input logic [31:0] first, input logic [31:0] last);
    @(posedge clk);
    #1;
    start       = 1'b1;
    nonce_first = first;
    nonce_last  = last;
    @(posedge clk);
    #1;
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("done_wait_expired", 608'(0), 608'(1));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_flags"}, 608'({hash_enable, busy, found, exhausted, timeout_err, done}),
             608'(0));
    check_eq({tag, "_block"}, block, 608'(0));
    check_eq({tag, "_nonce"}, 608'(nonce), 608'(0));
    check_eq({tag, "_target"}, 608'(target), 608'(0));
    check_eq({tag, "_attempts"}, 608'(attempts), 608'(0));
    check_eq({tag, "_found_nonce"}, 608'(found_nonce), 608'(0));
    check_eq({tag, "_found_hash"}, 608'(found_hash), 608'(0));
  endtask

  initial begin
    bit seen;
    int cnt, waited;
    bit bad;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0;
    block_in = {19{32'hC0DE_1234}}; target_in = {8{32'h0000_FFFF}};
    nonce_first = '0; nonce_last = '0;
    mute = 1'b0; hit_en = 1'b0; hit_val = '0;
    #3;
    check_zero("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Single hit.
    hit_en = 1'b1; hit_val = 32'h42A1_4695; he_count = 0;
    push_exp(32'h42A1_4690, 32'h42A1_469F, 1'b1, hit_val);
    do_start(32'h42A1_4690, 32'h42A1_469F);
    wait_done(200, seen);
    if (seen) begin
      check_eq("hit_found", 608'({found, exhausted, timeout_err, busy}), 608'(4'b1000));
      check_eq("hit_found_nonce", 608'(found_nonce), 608'(32'h42A1_4695));
      check_eq("hit_attempts", 608'(attempts), 608'(6));
      check_eq("hit_found_hash", 608'(found_hash), 608'({8{32'h9546_A142}}));
      check_eq("hit_pulses", 608'(he_count), 608'(6));
      check_eq("hit_block", block, {19{32'hC0DE_1234}});
      check_eq("hit_target", 608'(target), 608'({8{32'h0000_FFFF}}));
      @(negedge clk);
      check_eq("hit_done_width", 608'({done, found}), 608'(2'b01));
    end
    check_eq("hit_queue_empty", 608'(exp_q.size()), 608'(0));

    // Re-arm from FOUND; a start during WAIT must be ignored.
    hit_val = 32'h0000_0101; he_count = 0;
    push_exp(32'h100, 32'h102, 1'b1, hit_val);
    do_start(32'h100, 32'h102);
    @(negedge clk);
    check_eq("rearm_cleared", 608'({found, attempts, found_nonce, busy}),
             608'({1'b0, 33'd0, 32'd0, 1'b1}));
    @(posedge clk);
    #1;
    start = 1'b1; nonce_first = 32'h500; nonce_last = 32'h500;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200, seen);
    if (seen) begin
      check_eq("rearm_found_nonce", 608'(found_nonce), 608'(32'h101));
      check_eq("rearm_attempts", 608'({found, attempts}), 608'({1'b1, 33'd2}));
    end
    check_eq("rearm_queue_empty", 608'(exp_q.size()), 608'(0));

    // Exhaustion.
    hit_en = 1'b0; he_count = 0;
    push_exp(32'h10, 32'h13, 1'b0, 32'h0);
    do_start(32'h10, 32'h13);
    wait_done(200, seen);
    if (seen) begin
      check_eq("exh_flags", 608'({found, exhausted, timeout_err}), 608'(3'b010));
      check_eq("exh_attempts", 608'(attempts), 608'(4));
      check_eq("exh_pulses", 608'(he_count), 608'(4));
      check_eq("exh_found_nonce", 608'(found_nonce), 608'(0));
    end

    // Wrap through 0xFFFFFFFF.
    he_count = 0;
    push_exp(32'hFFFF_FFFE, 32'h1, 1'b0, 32'h0);
    do_start(32'hFFFF_FFFE, 32'h1);
    wait_done(200, seen);
    if (seen) begin
      check_eq("wrap_flags", 608'({found, exhausted}), 608'(2'b01));
      check_eq("wrap_attempts", 608'(attempts), 608'(4));
    end
    check_eq("wrap_queue_empty", 608'(exp_q.size()), 608'(0));

    // Timeout: core never finishes.
    mute = 1'b1;
    exp_q.push_back(32'h20);
    do_start(32'h20, 32'h30);
    @(negedge clk);
    check_eq("to_launch", 608'(hash_enable), 608'(1));
    waited = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        waited = i;
        break;
      end
    end
    check_eq("to_cycles", 608'(waited), 608'(8));
    check_eq("to_done", 608'({done, busy, attempts}), 608'({1'b1, 1'b0, 33'd0}));
    mute = 1'b0;

    // Abort during WAIT of the third hash.
    he_count = 0;
    push_exp(32'h0, 32'hF, 1'b0, 32'h0);
    do_start(32'h0, 32'hF);
    for (int i = 0; i < 100 && he_count < 3; i++) @(negedge clk);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("abort_idle", 608'({busy, found, exhausted, timeout_err, done}), 608'(0));
    cnt = he_count; bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || hash_enable || busy) bad = 1'b1;
    end
    check_eq("abort_quiet", 608'({bad, he_count}), 608'({1'b0, cnt}));

    // Asynchronous reset mid-search.
    he_count = 0;
    push_exp(32'h200, 32'h2FF, 1'b0, 32'h0);
    do_start(32'h200, 32'h2FF);
    for (int i = 0; i < 100 && he_count < 2; i++) @(negedge clk);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_zero("midrst");
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_after", 608'({busy, hash_enable}), 608'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
